// File: rtl/maxpool2x2_stream_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling stage.
// Each accepted pixel falls into exactly one of the roles in pos_kind_e.
package maxpool2x2_stream_pkg;

    typedef enum logic [1:0] {
        POS_HOLD    = 2'd0,
        POS_LBUF_WR = 2'd1,
        POS_EMIT    = 2'd2,
        POS_SKIP    = 2'd3
    } pos_kind_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_line_buffer.sv
// Line buffer holding the pairwise maxima of the upper row of each window.
// One write port and one asynchronous read port.
module pool_line_buffer #(
    parameter int DEPTH = 110,
    parameter int AW    = 7,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 signed max pooling over a planar raster stream without backpressure.
// Counters track the position of each accepted pixel; one pooled pixel per window, 1 clk after its last pixel.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int D          = 220,
    parameter int C          = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int HALF = D / 2;
    localparam int CW   = clog2_min1(D);
    localparam int CHW  = clog2_min1(C);
    localparam int AW   = clog2_min1(HALF);
    localparam bit ODD  = (D % 2) == 1;

    localparam logic [CW-1:0]  EDGE     = CW'(D - 1);
    localparam logic [CW-1:0]  WIN_LAST = CW'(2 * HALF - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(C - 1);

    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    pos_kind_e             kind;
    logic [AW-1:0]         lbuf_addr;
    logic [DATA_WIDTH-1:0] lbuf_rdata;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] win_max;
    logic                  lbuf_we;

    function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Odd D: the trailing column and row are counted but never join a window.
    always_comb begin
        kind = POS_SKIP;
        if (!(ODD && (col_q == EDGE)) && !(ODD && (row_q == EDGE))) begin
            if (!col_q[0]) begin
                kind = POS_HOLD;
            end else if (!row_q[0]) begin
                kind = POS_LBUF_WR;
            end else begin
                kind = POS_EMIT;
            end
        end
    end

    assign lbuf_addr = AW'(col_q >> 1);
    assign lbuf_we   = valid_in && (kind == POS_LBUF_WR);
    assign pair_max  = smax(hold_q, pxl_in);
    assign win_max   = smax(pair_max, lbuf_rdata);

    pool_line_buffer #(
        .DEPTH (HALF),
        .AW    (AW),
        .W     (DATA_WIDTH)
    ) u_lbuf (
        .clk     (clk),
        .we_i    (lbuf_we),
        .waddr_i (lbuf_addr),
        .wdata_i (pair_max),
        .raddr_i (lbuf_addr),
        .rdata_o (lbuf_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            hold_q       <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            hold_q       <= hold_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        ch_d   = ch_q;
        hold_d = hold_q;
        if (valid_in) begin
            if (kind == POS_HOLD) begin
                hold_d = pxl_in;
            end
            if (col_q == EDGE) begin
                col_d = '0;
                if (row_q == EDGE) begin
                    row_d = '0;
                    ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        valid_out_d  = valid_in && (kind == POS_EMIT);
        pxl_out_d    = valid_out_d ? win_max : pxl_out_q;
        frame_done_d = valid_out_d && (col_q == WIN_LAST) && (row_q == WIN_LAST)
                       && (ch_q == CH_LAST);
    end

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: three instances (D=4/C=1, D=5/C=1, D=4/C=3) checked
// against a pixel-array reference model through per-instance expected queues.
module tb_maxpool2x2_stream;

    typedef struct {
        logic [31:0] d;
        logic        fd;
        int          cyc;
    } exp_t;

    localparam int DD [3] = '{4, 5, 4};
    localparam int CC [3] = '{1, 1, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        vin   [3];
    logic [31:0] din   [3];
    logic [31:0] dout  [3];
    logic        vout  [3];
    logic        fdout [3];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q [3][$];
    exp_t mon_e;
    int   img   [3][5][5];
    int   mcol  [3];
    int   mrow  [3];
    int   mch   [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool2x2_stream #(.D(4), .C(1), .DATA_WIDTH(32)) u_d4 (
        .clk(clk), .reset(reset), .valid_in(vin[0]), .pxl_in(din[0]),
        .pxl_out(dout[0]), .valid_out(vout[0]), .frame_done(fdout[0]));

    maxpool2x2_stream #(.D(5), .C(1), .DATA_WIDTH(32)) u_d5 (
        .clk(clk), .reset(reset), .valid_in(vin[1]), .pxl_in(din[1]),
        .pxl_out(dout[1]), .valid_out(vout[1]), .frame_done(fdout[1]));

    maxpool2x2_stream #(.D(4), .C(3), .DATA_WIDTH(32)) u_d4c3 (
        .clk(clk), .reset(reset), .valid_in(vin[2]), .pxl_in(din[2]),
        .pxl_out(dout[2]), .valid_out(vout[2]), .frame_done(fdout[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic int smax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcol[k] = 0;
            mrow[k] = 0;
            mch[k]  = 0;
            exp_q[k].delete();
        end
    endtask

    // Called at posedge+1; presents one beat to instance k for one clock.
    task automatic drive(input int k, input int v);
        int   r, c, h;
        exp_t e;
        r = mrow[k];
        c = mcol[k];
        h = DD[k] / 2;
        img[k][r][c] = v;
        if ((c % 2 == 1) && (r % 2 == 1) && (c < 2 * h) && (r < 2 * h)) begin
            e.d   = 32'(smax(smax(img[k][r-1][c-1], img[k][r-1][c]),
                             smax(img[k][r][c-1], v)));
            e.fd  = (c == 2 * h - 1) && (r == 2 * h - 1) && (mch[k] == CC[k] - 1);
            e.cyc = cyc + 1;
            exp_q[k].push_back(e);
        end
        if (c == DD[k] - 1) begin
            mcol[k] = 0;
            if (r == DD[k] - 1) begin
                mrow[k] = 0;
                mch[k]  = (mch[k] == CC[k] - 1) ? 0 : mch[k] + 1;
            end else begin
                mrow[k] = r + 1;
            end
        end else begin
            mcol[k] = c + 1;
        end
        din[k] = 32'(v);
        vin[k] = 1'b1;
        @(posedge clk);
        #1;
        vin[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (exp_q[k].size() > 0 && exp_q[k][0].cyc == cyc) begin
                    mon_e = exp_q[k].pop_front();
                    chk($sformatf("u%0d_valid", k), 32'(vout[k]), 32'd1);
                    chk($sformatf("u%0d_data", k), dout[k], mon_e.d);
                    chk($sformatf("u%0d_frame_done", k), 32'(fdout[k]), 32'(mon_e.fd));
                end else begin
                    chk($sformatf("u%0d_quiet", k), {30'd0, vout[k], fdout[k]}, 32'd0);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b0;
            din[k] = '0;
        end
        model_reset();
        idle(2);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_rst_pxl", k), dout[k], 32'd0);
            chk($sformatf("u%0d_rst_valid", k), 32'(vout[k]), 32'd0);
            chk($sformatf("u%0d_rst_fd", k), 32'(fdout[k]), 32'd0);
        end
        reset = 1'b0;
        idle(1);

        // D=4 ascending raster, back to back
        for (int i = 0; i < 16; i++) drive(0, i);
        idle(3);

        // D=4 negative values exercise the signed compare
        for (int i = 0; i < 16; i++) drive(0, -i);
        idle(3);

        // D=5: trailing column/row never emitted
        for (int i = 0; i < 25; i++) drive(1, i);
        idle(3);

        // D=4, C=3: two back-to-back frames
        for (int f = 0; f < 2; f++)
            for (int n = 0; n < 3; n++)
                for (int i = 0; i < 16; i++) drive(2, 16 * n + i);
        idle(3);

        // D=4 with random gaps
        for (int i = 0; i < 16; i++) begin
            drive(0, i);
            idle($urandom_range(0, 3));
        end
        idle(3);

        // Mid-frame reset after 7 pixels, then a clean frame
        for (int i = 0; i < 7; i++) drive(0, i);
        idle(1);
        reset = 1'b1;
        #1;
        chk("midrst_pxl_async", dout[0], 32'd0);
        chk("midrst_valid_async", 32'(vout[0]), 32'd0);
        chk("midrst_fd_async", 32'(fdout[0]), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_pxl_held", dout[0], 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) drive(0, i);
        idle(4);

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_queue_drained", k), 32'(exp_q[k].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
